pipeline_stall_controller: RTL and testbench

- Central hazard sequencer for the 5-stage ARM pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazards: load-use, taken branch, and multi-cycle data-memory wait. Memory wait has the highest priority.
- Also keeps a sticky memory-timeout flag and a stall performance counter.

---
 rtl/pipeline_stall_controller.sv | 167 ++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer for the 5-stage pipeline: resolves memory wait, taken branch
// and load-use hazards into per-register enables/flushes, with timeout and stall stats.
module pipeline_stall_controller #(
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned WAIT_MAX    = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  id_rn,
   input  logic [3:0]  id_rm,
   input  logic        id_uses_rn,
   input  logic        id_uses_rm,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic [3:0]  ex_rd,
   input  logic        branch_taken_ex,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        if_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        memwb_flush,
   output logic        mem_timeout,
   output logic [15:0] stall_count
);

   localparam int unsigned FLUSH_W = 4;
   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned CNT_W   = 16;
   localparam bit          BR_MULTI = (FLUSH_DEPTH > 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BR_FLUSH = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]   stall_count_q, stall_count_d;

   logic memstall;
   logic loaduse;

   assign memstall = mem_req & ~mem_ready;
   assign loaduse  = ex_valid & ex_is_load &
                     ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;

   // Next-state and Mealy output decode
   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      stall_count_d = stall_count_q;
      if_en         = 1'b1;
      ifid_en       = 1'b1;
      ifid_flush    = 1'b0;
      idex_en       = 1'b1;
      idex_flush    = 1'b0;
      exmem_en      = 1'b1;
      memwb_flush   = 1'b0;

      case (state_q)
         RUN: begin
            if (memstall) begin
               if_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               state_d     = MEM_WAIT;
               wait_cnt_d  = WAIT_W'(1);
            end else if (branch_taken_ex) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (BR_MULTI) begin
                  state_d     = BR_FLUSH;
                  flush_cnt_d = FLUSH_W'(FLUSH_DEPTH - 1);
               end
            end else if (loaduse) begin
               if_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end

         BR_FLUSH: begin
            // A memory stall parks the remaining flush count; MEM_WAIT resumes it on exit
            if (memstall) begin
               if_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               state_d     = MEM_WAIT;
               wait_cnt_d  = WAIT_W'(1);
            end else begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
               if (flush_cnt_q == FLUSH_W'(1)) begin
                  state_d = RUN;
               end
            end
         end

         MEM_WAIT: begin
            if (mem_ready || (wait_cnt_q == WAIT_W'(WAIT_MAX))) begin
               if (!mem_ready) begin
                  mem_timeout_d = 1'b1;
               end
               wait_cnt_d = '0;
               state_d    = (flush_cnt_q != '0) ? BR_FLUSH : RUN;
            end else begin
               if_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
               wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase

      if (!if_en && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end

      // Reset holds every register stage in bubble and clears all bookkeeping
      if (reset) begin
         state_d       = RUN;
         flush_cnt_d   = '0;
         wait_cnt_d    = '0;
         mem_timeout_d = 1'b0;
         stall_count_d = '0;
         if_en         = 1'b0;
         ifid_en       = 1'b0;
         ifid_flush    = 1'b1;
         idex_en       = 1'b0;
         idex_flush    = 1'b1;
         exmem_en      = 1'b0;
         memwb_flush   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed hazard scenarios plus random traffic,
// all checked every cycle against a hazard-rule reference model.
module tb_pipeline_stall_controller;

   localparam int unsigned FLUSH_DEPTH = 2;
   localparam int unsigned WAIT_MAX    = 15;

   // Output vector order: {if_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
   localparam logic [6:0] O_DEF   = 7'b1101010;
   localparam logic [6:0] O_RST   = 7'b0010101;
   localparam logic [6:0] O_STALL = 7'b0000001;
   localparam logic [6:0] O_FLUSH = 7'b1111110;
   localparam logic [6:0] O_LU    = 7'b0001110;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  id_rn, id_rm, ex_rd;
   logic        id_uses_rn, id_uses_rm, ex_valid, ex_is_load;
   logic        branch_taken_ex, mem_req, mem_ready;
   logic        if_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
   logic        mem_timeout;
   logic [15:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Reference model state
   int m_wait       = 0;   // cycles already stalled on the outstanding access, 0 = none
   int m_flush_left = 0;   // branch flush cycles still owed
   bit m_timeout    = 1'b0;
   int m_stalls     = 0;

   pipeline_stall_controller #(.FLUSH_DEPTH(FLUSH_DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
      .if_en(if_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
      .mem_timeout(mem_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rn = 4'd0; id_rm = 4'd0; ex_rd = 4'd0;
      id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
      branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
   endtask

   task automatic set_loaduse_r3();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd3;
      id_uses_rn = 1'b1; id_rn = 4'd3;
   endtask

   // Reference model: evaluate the hazard rules on the current cycle, compare, then advance
   always @(negedge clk) begin
      if (chk_en) begin
         logic [6:0] exp_o;
         logic       lu, ms;
         int         nw, nf, ns;
         bit         nt;
         lu = ex_valid & ex_is_load &
              ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
         ms = mem_req & ~mem_ready;
         nw = m_wait; nf = m_flush_left; nt = m_timeout; ns = m_stalls;
         if (reset) begin
            exp_o = O_RST;
            nw = 0; nf = 0; nt = 1'b0; ns = 0;
         end else begin
            if (m_wait > 0) begin
               if (mem_ready) begin
                  exp_o = O_DEF; nw = 0;
               end else if (m_wait == int'(WAIT_MAX)) begin
                  exp_o = O_DEF; nw = 0; nt = 1'b1;
               end else begin
                  exp_o = O_STALL; nw = m_wait + 1;
               end
            end else if (ms) begin
               exp_o = O_STALL; nw = 1;
            end else if (m_flush_left > 0) begin
               exp_o = O_FLUSH; nf = m_flush_left - 1;
            end else if (branch_taken_ex) begin
               exp_o = O_FLUSH; nf = int'(FLUSH_DEPTH) - 1;
            end else if (lu) begin
               exp_o = O_LU;
            end else begin
               exp_o = O_DEF;
            end
            if (!exp_o[6] && ns < 65535) ns = ns + 1;
         end
         check("model_outputs",
               {25'd0, if_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush},
               {25'd0, exp_o});
         check("model_mem_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
         check("model_stall_count", {16'd0, stall_count}, 32'(m_stalls));
         m_wait = nw; m_flush_left = nf; m_timeout = nt; m_stalls = ns;
      end
   end

   initial begin
      int ready_pct;
      reset = 1'b1;
      idle();
      #1;
      check("reset_if_en", {31'd0, if_en}, 32'd0);
      check("reset_ifid_flush", {31'd0, ifid_flush}, 32'd1);
      check("reset_memwb_flush", {31'd0, memwb_flush}, 32'd1);
      do_reset();
      chk_en = 1'b1;
      check("reset_stall_count", {16'd0, stall_count}, 32'd0);
      check("reset_mem_timeout", {31'd0, mem_timeout}, 32'd0);

      // Load-use on r3: one bubble
      set_loaduse_r3();
      #1;
      check("lu_if_en", {31'd0, if_en}, 32'd0);
      check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
      check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
      check("lu_exmem_en", {31'd0, exmem_en}, 32'd1);
      step();
      idle();
      #1;
      check("lu_after_if_en", {31'd0, if_en}, 32'd1);
      check("lu_after_ifid_en", {31'd0, ifid_en}, 32'd1);
      check("lu_stall_count", {16'd0, stall_count}, 32'd1);

      // Taken branch: exactly two flush cycles
      step();
      branch_taken_ex = 1'b1;
      #1;
      check("br_flush_c1", {30'd0, ifid_flush, idex_flush}, 32'd3);
      check("br_if_en_c1", {31'd0, if_en}, 32'd1);
      step();
      branch_taken_ex = 1'b0;
      #1;
      check("br_flush_c2", {30'd0, ifid_flush, idex_flush}, 32'd3);
      check("br_if_en_c2", {31'd0, if_en}, 32'd1);
      step();
      #1;
      check("br_flush_c3", {30'd0, ifid_flush, idex_flush}, 32'd0);

      // Three-cycle memory wait
      do_reset();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("mw_if_en", {31'd0, if_en}, 32'd0);
         check("mw_exmem_en", {31'd0, exmem_en}, 32'd0);
         check("mw_memwb_flush", {31'd0, memwb_flush}, 32'd1);
         step();
      end
      mem_ready = 1'b1;
      #1;
      check("mw_ready_if_en", {31'd0, if_en}, 32'd1);
      check("mw_ready_exmem_en", {31'd0, exmem_en}, 32'd1);
      step();
      idle();
      #1;
      check("mw_stall_count", {16'd0, stall_count}, 32'd3);

      // All three hazards at once: memory wins, branch flushes after ready
      do_reset();
      mem_req = 1'b1; branch_taken_ex = 1'b1;
      set_loaduse_r3();
      #1;
      check("all3_memwb_flush", {31'd0, memwb_flush}, 32'd1);
      check("all3_ifid_flush", {31'd0, ifid_flush}, 32'd0);
      step();
      mem_ready = 1'b1;
      #1;
      check("all3_ready_flush", {30'd0, ifid_flush, idex_flush}, 32'd0);
      check("all3_ready_if_en", {31'd0, if_en}, 32'd1);
      step();
      mem_req = 1'b0; mem_ready = 1'b0;
      #1;
      check("all3_br_c1", {30'd0, ifid_flush, idex_flush}, 32'd3);
      step();
      idle();
      #1;
      check("all3_br_c2", {30'd0, ifid_flush, idex_flush}, 32'd3);
      step();
      #1;
      check("all3_br_c3", {30'd0, ifid_flush, idex_flush}, 32'd0);

      // Timeout: 15 stalled cycles, then abandon and resume
      do_reset();
      mem_req = 1'b1;
      for (int i = 0; i < int'(WAIT_MAX); i++) begin
         #1;
         check("to_stall", {31'd0, if_en}, 32'd0);
         step();
      end
      mem_req = 1'b0;
      #1;
      check("to_resume_if_en", {31'd0, if_en}, 32'd1);
      check("to_flag_pre", {31'd0, mem_timeout}, 32'd0);
      step();
      #1;
      check("to_flag_set", {31'd0, mem_timeout}, 32'd1);
      check("to_stall_count", {16'd0, stall_count}, 32'd15);
      repeat (3) step();
      check("to_flag_sticky", {31'd0, mem_timeout}, 32'd1);

      // Reset in the second wait cycle clears everything
      mem_req = 1'b1;
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst_mid_if_en", {31'd0, if_en}, 32'd0);
      check("rst_mid_ifid_flush", {31'd0, ifid_flush}, 32'd1);
      step();
      reset = 1'b0;
      mem_req = 1'b0;
      #1;
      check("rst_mid_timeout", {31'd0, mem_timeout}, 32'd0);
      check("rst_mid_stall_count", {16'd0, stall_count}, 32'd0);
      check("rst_mid_if_en_run", {31'd0, if_en}, 32'd1);

      // Random traffic with varying memory latency
      for (int blk = 0; blk < 6; blk++) begin
         ready_pct = (blk % 3 == 0) ? 8 : ((blk % 3 == 1) ? 50 : 90);
         for (int c = 0; c < 500; c++) begin
            reset           = ($urandom_range(0, 99) < 2);
            id_rn           = 4'($urandom_range(0, 3));
            id_rm           = 4'($urandom_range(0, 3));
            ex_rd           = 4'($urandom_range(0, 3));
            id_uses_rn      = 1'($urandom_range(0, 1));
            id_uses_rm      = 1'($urandom_range(0, 1));
            ex_valid        = ($urandom_range(0, 99) < 80);
            ex_is_load      = ($urandom_range(0, 99) < 40);
            branch_taken_ex = ($urandom_range(0, 99) < 12);
            mem_req         = ($urandom_range(0, 99) < 35);
            mem_ready       = ($urandom_range(0, 99) < ready_pct);
            step();
         end
      end
      reset = 1'b0;
      idle();
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
